// File: rtl/cr16_pc_sequencer_if.sv
// CR16 shared memory port handshake between the PC sequencer and the memory arbiter.
// The sequencer holds the request until a one-cycle acknowledge arrives.
interface cr16_pc_sequencer_if;
  logic O_MEM_REQ;
  logic O_MEM_WE;
  logic O_MEM_ADDR_SELECT;
  logic I_MEM_ACK;

  modport master (
    output O_MEM_REQ,
    output O_MEM_WE,
    output O_MEM_ADDR_SELECT,
    input  I_MEM_ACK
  );

  modport slave (
    input  O_MEM_REQ,
    input  O_MEM_WE,
    input  O_MEM_ADDR_SELECT,
    output I_MEM_ACK
  );
endinterface

// File: rtl/cr16_pc_sequencer.sv
// CR16 multi-cycle control FSM: fetch, decode, execute, memory, PC update.
// Owns PC load/enable controls, branch evaluation and memory/RF strobes.
module cr16_pc_sequencer #(
  parameter int P_ADDRESS_WIDTH     = 16,
  parameter int P_INSTRUCTION_WIDTH = 16
) (
  input  logic                           I_CLK,
  input  logic                           I_NRESET,
  input  logic [P_INSTRUCTION_WIDTH-1:0] I_INSTRUCTION,
  input  logic [P_ADDRESS_WIDTH-1:0]     I_PC,
  input  logic [P_ADDRESS_WIDTH-1:0]     I_TARGET,
  input  logic [4:0]                     I_FLAGS,
  cr16_pc_sequencer_if.master            mem,
  output logic                           O_IR_LOAD,
  output logic                           O_RF_WRITE,
  output logic [1:0]                     O_WB_SELECT,
  output logic                           O_PC_ENABLE,
  output logic [P_ADDRESS_WIDTH-1:0]     O_PC_ADDRESS,
  output logic                           O_PC_ADDRESS_SELECT,
  output logic                           O_PC_ADDRESS_SELECT_INCREMENT,
  output logic [4:0]                     O_STATE
);

  localparam int S_FETCH = 0;
  localparam int S_DEC   = 1;
  localparam int S_EXE   = 2;
  localparam int S_MEM   = 3;
  localparam int S_PCU   = 4;

  localparam logic [4:0] ST_FETCH = 5'b00001;
  localparam logic [4:0] ST_DEC   = 5'b00010;
  localparam logic [4:0] ST_EXE   = 5'b00100;
  localparam logic [4:0] ST_MEM   = 5'b01000;
  localparam logic [4:0] ST_PCU   = 5'b10000;

  logic [4:0] r_state;
  logic [4:0] w_next;

  logic r_alu;
  logic r_jal;
  logic r_load;
  logic r_stor;
  logic [P_ADDRESS_WIDTH-1:0] r_pc_address;
  logic r_pc_sel;

  logic [3:0] w_op;
  logic [3:0] w_sub;
  logic [3:0] w_cond;
  logic w_bcond;
  logic w_jcond;
  logic w_jal;
  logic w_load;
  logic w_stor;
  logic w_nop;
  logic w_cmp;
  logic w_alu;
  logic w_true;
  logic w_n, w_z, w_f, w_l, w_c;
  logic [P_ADDRESS_WIDTH-1:0] w_disp;

  assign w_op   = I_INSTRUCTION[15:12];
  assign w_sub  = I_INSTRUCTION[7:4];
  assign w_cond = I_INSTRUCTION[11:8];
  assign {w_n, w_z, w_f, w_l, w_c} = I_FLAGS;

  assign w_bcond = (w_op == 4'hC);
  assign w_jcond = (w_op == 4'h4) && (w_sub == 4'hC);
  assign w_jal   = (w_op == 4'h4) && (w_sub == 4'h8);
  assign w_load  = (w_op == 4'h4) && (w_sub == 4'h0);
  assign w_stor  = (w_op == 4'h4) && (w_sub == 4'h4);
  assign w_nop   = (I_INSTRUCTION == '0);
  assign w_cmp   = (w_op == 4'hB) ||
                   ((w_op == 4'h0) && (w_sub == 4'hB));
  assign w_alu   = !(w_bcond | w_jcond | w_jal | w_load |
                     w_stor | w_nop | w_cmp);

  assign w_disp = {{(P_ADDRESS_WIDTH-8){I_INSTRUCTION[7]}},
                   I_INSTRUCTION[7:0]};

  always_comb begin
    w_true = 1'b0;
    case (w_cond)
      4'h0: w_true = w_z;
      4'h1: w_true = !w_z;
      4'h2: w_true = w_c;
      4'h3: w_true = !w_c;
      4'h4: w_true = w_l;
      4'h5: w_true = !w_l;
      4'h6: w_true = w_n;
      4'h7: w_true = !w_n;
      4'h8: w_true = w_f;
      4'h9: w_true = !w_f;
      4'hA: w_true = !w_l && !w_z;
      4'hB: w_true = w_l || w_z;
      4'hC: w_true = !w_n && !w_z;
      4'hD: w_true = w_n || w_z;
      4'hE: w_true = 1'b1;
      default: w_true = 1'b0;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      r_state      <= ST_FETCH;
      r_alu        <= 1'b0;
      r_jal        <= 1'b0;
      r_load       <= 1'b0;
      r_stor       <= 1'b0;
      r_pc_address <= '0;
      r_pc_sel     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state[S_DEC]) begin
        r_alu  <= w_alu;
        r_jal  <= w_jal;
        r_load <= w_load;
        r_stor <= w_stor;
        // PC controls stay frozen from here through PC_UPDATE
        if (w_bcond && w_true) begin
          r_pc_address <= I_PC + w_disp;
          r_pc_sel     <= 1'b1;
        end else if (w_jal || (w_jcond && w_true)) begin
          r_pc_address <= I_TARGET;
          r_pc_sel     <= 1'b1;
        end else begin
          r_pc_address <= '0;
          r_pc_sel     <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next = ST_FETCH;
    unique case (1'b1)
      r_state[S_FETCH]: w_next = mem.I_MEM_ACK ? ST_DEC : ST_FETCH;
      r_state[S_DEC]:   w_next = ST_EXE;
      r_state[S_EXE]:   w_next = (r_load | r_stor) ? ST_MEM : ST_PCU;
      r_state[S_MEM]:   w_next = mem.I_MEM_ACK ? ST_PCU : ST_MEM;
      r_state[S_PCU]:   w_next = ST_FETCH;
      default:          w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    mem.O_MEM_REQ         = 1'b0;
    mem.O_MEM_WE          = 1'b0;
    mem.O_MEM_ADDR_SELECT = 1'b0;
    O_IR_LOAD             = 1'b0;
    O_RF_WRITE            = 1'b0;
    O_WB_SELECT           = 2'd0;
    // strobes are forced low while reset is held
    if (I_NRESET) begin
      unique case (1'b1)
        r_state[S_FETCH]: begin
          mem.O_MEM_REQ = 1'b1;
          O_IR_LOAD     = mem.I_MEM_ACK;
        end
        r_state[S_EXE]: begin
          O_RF_WRITE  = r_alu | r_jal;
          O_WB_SELECT = r_jal ? 2'd2 : 2'd0;
        end
        r_state[S_MEM]: begin
          mem.O_MEM_REQ         = 1'b1;
          mem.O_MEM_ADDR_SELECT = 1'b1;
          mem.O_MEM_WE          = r_stor;
          O_RF_WRITE            = r_load & mem.I_MEM_ACK;
          O_WB_SELECT           = r_load ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign O_PC_ENABLE                   = r_state[S_PCU];
  assign O_PC_ADDRESS                  = r_pc_address;
  assign O_PC_ADDRESS_SELECT           = r_pc_sel;
  assign O_PC_ADDRESS_SELECT_INCREMENT = 1'b0;
  assign O_STATE                       = r_state;

endmodule

// File: doc/cr16_pc_sequencer.md
Name: cr16_pc_sequencer

Overview:
- Multi-cycle control FSM for the CR16 core: fetch -> decode -> execute -> memory -> PC update.
- Owns the program counter's control inputs: address, address select, increment select and the single-cycle enable pulse that clocks the PC.
- Evaluates branch and jump conditions from the PSR flags and computes branch targets.
- Hands load/store to the shared memory port with a request/acknowledge handshake, and drives register-file write strobes.

Parameters:
- P_ADDRESS_WIDTH, 16: width of PC, branch target and memory address.
- P_INSTRUCTION_WIDTH, 16: width of the instruction word. Must be 16; CR16 field positions are fixed.

Ports:
- I_CLK  input  1  system clock; all state changes on rising edge.
- I_NRESET  input  1  asynchronous, active-low reset.
- I_INSTRUCTION  input  P_INSTRUCTION_WIDTH  instruction register contents; valid from DECODE onward.
- I_PC  input  P_ADDRESS_WIDTH  current PC value (address of the executing instruction).
- I_TARGET  input  P_ADDRESS_WIDTH  Rtarget register value for Jcond/JAL.
- I_FLAGS  input  5  PSR flags {N,Z,F,L,C}, bits [4:0].
- I_MEM_ACK  input  1  memory port completion; one-cycle pulse.
- O_MEM_REQ  output  1  memory request; held until ack.
- O_MEM_WE  output  1  store request qualifier.
- O_MEM_ADDR_SELECT  output  1  0 = PC (fetch), 1 = Raddr (load/store).
- O_IR_LOAD  output  1  instruction register capture strobe.
- O_RF_WRITE  output  1  register-file write strobe.
- O_WB_SELECT  output  2  writeback source: 0 = ALU, 1 = memory, 2 = link (I_PC+1).
- O_PC_ENABLE  output  1  PC clock/enable pulse.
- O_PC_ADDRESS  output  P_ADDRESS_WIDTH  PC load value.
- O_PC_ADDRESS_SELECT  output  1  1 = load O_PC_ADDRESS; 0 = PC+1.
- O_PC_ADDRESS_SELECT_INCREMENT  output  1  always 0 from this block.
- O_STATE  output  5  one-hot state, for debug.

Behaviour:
- State encoding: one-hot {PC_UPDATE, MEM, EXECUTE, DECODE, FETCH}, bits [4:0].
  - O_PC_ENABLE is the PC_UPDATE flop output directly, so it is glitch-free.
- Reset (asynchronous, active-low):
  - State = FETCH.
  - All strobes, O_PC_ADDRESS and both select outputs are 0.
  - Reset mid-operation aborts the instruction; no PC pulse and no RF write are issued.
- FETCH:
  - Outputs: O_MEM_REQ=1, O_MEM_ADDR_SELECT=0.
  - On I_MEM_ACK: O_IR_LOAD=1 in that cycle, then go to DECODE. Otherwise stay in FETCH (unbounded wait).
- DECODE (1 cycle): classify the instruction and go to EXECUTE.
  - Bcond: opcode [15:12]=1100.
  - Jcond: [15:12]=0100 and [7:4]=1100.
  - JAL: [15:12]=0100 and [7:4]=1000.
  - LOAD: [15:12]=0100 and [7:4]=0000.
  - STOR: [15:12]=0100 and [7:4]=0100.
  - NOP: instruction == 0.
  - CMP-class (no RF write): [15:12]=1011, or [15:12]=0000 with [7:4]=1011.
  - ALU: everything else.
- Condition field: bits [11:8].
  - EQ 0000: Z. NE 0001: !Z.
  - CS 0010: C. CC 0011: !C.
  - HI 0100: L. LS 0101: !L.
  - GT 0110: N. LE 0111: !N.
  - FS 1000: F. FC 1001: !F.
  - LO 1010: !L&!Z. HS 1011: L|Z.
  - LT 1100: !N&!Z. GE 1101: N|Z.
  - UC 1110: true. 1111: false.
- Flags are sampled at DECODE.
- PC control outputs are registered on the DECODE->EXECUTE edge and held stable through PC_UPDATE:
  - Taken Bcond: address = I_PC + sign-extended [7:0], select=1. Arithmetic is modulo 2^P_ADDRESS_WIDTH.
  - Taken Jcond, and JAL (always taken): address = I_TARGET, select=1.
  - All other cases: select=0; PC increments by 1.
- EXECUTE (1 cycle):
  - ALU: O_RF_WRITE=1, O_WB_SELECT=0.
  - JAL: O_RF_WRITE=1, O_WB_SELECT=2.
  - LOAD/STOR: go to MEM. All other classes go to PC_UPDATE.
- MEM:
  - Outputs: O_MEM_REQ=1, O_MEM_ADDR_SELECT=1, O_MEM_WE=1 for STOR.
  - On I_MEM_ACK: LOAD asserts O_RF_WRITE=1, O_WB_SELECT=1 in that cycle; then go to PC_UPDATE.
- PC_UPDATE (1 cycle): O_PC_ENABLE=1, then go to FETCH.
- Strobe rules:
  - O_IR_LOAD, O_RF_WRITE and O_PC_ENABLE are each high at most one cycle per instruction.
  - O_RF_WRITE is never asserted for Bcond, Jcond, STOR, NOP or CMP-class.
  - I_MEM_ACK outside FETCH/MEM is ignored.
- Latency:
  - Non-memory instruction: 4 cycles with zero-wait ack.
  - Load/store: 5 cycles with zero-wait ack.

Test Plan:
- Reset held low, then released; ALU instruction 0x0512 (ADD), ack immediate:
  - States FETCH, DECODE, EXECUTE, PC_UPDATE.
  - One RF write with WB_SELECT=0.
  - PC_ENABLE pulse with select=0.
- Bcond EQ 0xC0FE, I_PC=0x0010, Z=1:
  - O_PC_ADDRESS=0x000E, select=1.
  - With Z=0: select=0.
  - No RF write in either case.
- JAL 0x4E83 with I_TARGET=0x1234, I_PC=0x0040:
  - RF write with WB_SELECT=2.
  - PC_UPDATE with address=0x1234, select=1.
- LOAD 0x4201 with ack delayed 3 cycles in MEM:
  - O_MEM_REQ and ADDR_SELECT=1 are held for the full wait.
  - RF write with WB_SELECT=1 in the ack cycle.
  - STOR: MEM_WE=1 and no RF write.
- Bcond UC 0xCE7F at I_PC=0xFFF0:
  - Target wraps to 0x006F.
  - Condition 1111 is never taken.
- Assert I_NRESET low during MEM:
  - Immediate return to FETCH with all outputs 0.
  - No PC_ENABLE pulse.
